// File: rtl/_mux_arb.sv
// N-input valid/ready multiplexer with fixed-priority, round-robin or forced-select
// arbitration, feeding a single registered output stage.
module _mux_arb #(
    parameter int BIT_WIDTH = 8,
    parameter int n         = BIT_WIDTH,
    parameter int num_in    = 16,
    localparam int sel_w    = $clog2(num_in)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [sel_w-1:0]      sel,
    input  logic [num_in-1:0]     in_valid,
    input  logic [num_in*n-1:0]   in_data,
    output logic [num_in-1:0]     in_ready,
    output logic                  out_valid,
    output logic [n-1:0]          out_data,
    output logic [sel_w-1:0]      out_src,
    input  logic                  out_ready
);

    localparam logic [1:0]       MODE_RR    = 2'b01;
    localparam logic [1:0]       MODE_FORCE = 2'b10;
    localparam logic [sel_w-1:0] LAST_IDX   = sel_w'(num_in - 1);

    logic             r_out_valid;
    logic [n-1:0]     r_out_data;
    logic [sel_w-1:0] r_out_src;
    logic [sel_w-1:0] r_rr_ptr;

    logic             w_load_en;
    logic             w_grant_valid;
    logic [sel_w-1:0] w_grant_idx;
    logic [n-1:0]     w_grant_data;

    assign w_load_en = !r_out_valid || out_ready;

    // Reserved mode 11 falls into the fixed-priority default branch.
    always_comb begin : p_arbitrate
        int rr_idx;
        rr_idx        = 0;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        case (mode)
            MODE_RR: begin
                for (int k = 0; k < num_in; k++) begin
                    rr_idx = int'(r_rr_ptr) + k;
                    if (rr_idx >= num_in) rr_idx = rr_idx - num_in;
                    if (!w_grant_valid && in_valid[rr_idx]) begin
                        w_grant_valid = 1'b1;
                        w_grant_idx   = sel_w'(rr_idx);
                    end
                end
            end
            MODE_FORCE: begin
                if ((int'(sel) < num_in) && in_valid[sel]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = sel;
                end
            end
            default: begin
                for (int k = num_in - 1; k >= 0; k--) begin
                    if (in_valid[k]) begin
                        w_grant_valid = 1'b1;
                        w_grant_idx   = sel_w'(k);
                    end
                end
            end
        endcase
    end

    assign w_grant_data = in_data[int'(w_grant_idx)*n +: n];

    always_comb begin : p_ready
        in_ready = '0;
        if (w_load_en && w_grant_valid && rst_n) begin
            in_ready[w_grant_idx] = 1'b1;
        end
    end

    // A load with no grant drains the stage; data and source keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load_en) begin
            if (w_grant_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_src   <= w_grant_idx;
                if (mode == MODE_RR) begin
                    r_rr_ptr <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb__mux_arb.sv
// Bench for _mux_arb (n=8, num_in=4): directed scenarios plus random traffic,
// checked against a transaction-level model of the arbiter and output register.
module tb__mux_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_valid;
    logic [7:0]  m_data;
    int          m_src;
    int          m_rr;
    logic [3:0]  exp_ready;
    logic [3:0]  got_ready;

    _mux_arb #(.n(8), .num_in(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .sel      (sel),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        if (mode == 2'b01) begin
            for (int k = 0; k < 4; k++)
                if (in_valid[(m_rr + k) % 4]) return (m_rr + k) % 4;
            return -1;
        end
        if (mode == 2'b10) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 0; k < 4; k++)
            if (in_valid[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 8'h00;
        m_src   = 0;
        m_rr    = 0;
    endtask

    // One clock of traffic with the inputs already driven; records ready and
    // advances the model across the edge, leaving time at posedge+1.
    task automatic cycle();
        int g;
        bit le;
        #1;
        le        = !m_valid || out_ready;
        g         = exp_grant();
        exp_ready = (le && g >= 0) ? 4'(1 << g) : 4'b0000;
        got_ready = in_ready;
        @(posedge clk);
        #1;
        if (le) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = in_data[g*8 +: 8];
                m_src   = g;
                if (mode == 2'b01) m_rr = (g + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'b00; sel = 2'd0; in_valid = 4'b1111;
        in_data = 32'h44332211; out_ready = 1'b1;
        model_reset();
        #2;
        checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_state ready=%b valid=%b data=%h src=%0d required 0000/0/00/0",
                     in_ready, out_valid, out_data, out_src);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        checks++;
        if (got_ready !== 4'b0001 || out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL reset_first_grant ready=%b valid=%b src=%0d data=%h required 0001/1/0/11",
                     got_ready, out_valid, out_src, out_data);
        end
    endtask

    task automatic test_fixed_priority();
        mode = 2'b00; in_valid = 4'b1010; in_data = 32'h33221100; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (got_ready !== 4'b0010 || got_ready !== exp_ready || out_data !== 8'h11 || out_src !== 2'd1) begin
                errors++;
                $display("FAIL fixed_prio[%0d] ready=%b data=%h src=%0d required 0010/11/1",
                         i, got_ready, out_data, out_src);
            end
        end
    endtask

    task automatic test_round_robin();
        int seq [5] = '{0, 1, 2, 3, 0};
        mode = 2'b01; in_valid = 4'b1111; in_data = 32'hD3C2B1A0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b1 || int'(out_src) != seq[i] || out_src !== 2'(m_src)
                || out_data !== m_data || got_ready !== exp_ready) begin
                errors++;
                $display("FAIL round_robin[%0d] valid=%b src=%0d data=%h ready=%b required 1/%0d/%h/%b",
                         i, out_valid, out_src, out_data, got_ready, seq[i], m_data, exp_ready);
            end
        end
    endtask

    task automatic test_forced_select();
        mode = 2'b10; sel = 2'd2; in_valid = 4'b0111; in_data = 32'h77665544; out_ready = 1'b1;
        cycle();
        checks++;
        if (got_ready !== 4'b0100 || out_src !== 2'd2 || out_data !== 8'h66 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL forced_grant ready=%b src=%0d data=%h valid=%b required 0100/2/66/1",
                     got_ready, out_src, out_data, out_valid);
        end
        in_valid = 4'b0011;
        cycle();
        checks++;
        if (got_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'h66) begin
            errors++;
            $display("FAIL forced_nogrant ready=%b valid=%b data=%h required 0000/0/66",
                     got_ready, out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        mode = 2'b01; in_valid = 4'b1111; in_data = 32'h9C8B7A69; out_ready = 1'b1;
        cycle();
        checks++;
        if (out_src !== 2'd1 || out_data !== 8'h7A) begin
            errors++;
            $display("FAIL bp_load src=%0d data=%h required 1/7a", out_src, out_data);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom();
            cycle();
            checks++;
            if (got_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h7A || out_src !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d] ready=%b valid=%b data=%h src=%0d required 0000/1/7a/1",
                         i, got_ready, out_valid, out_data, out_src);
            end
        end
        in_data = 32'h9C8B7A69;
        out_ready = 1'b1;
        cycle();
        checks++;
        if (got_ready !== 4'b0100 || out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 8'h8B) begin
            errors++;
            $display("FAIL bp_pop_load ready=%b valid=%b src=%0d data=%h required 0100/1/2/8b",
                     got_ready, out_valid, out_src, out_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            mode      = 2'($urandom_range(0, 3));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom());
            in_data   = $urandom();
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            checks++;
            if (got_ready !== exp_ready || out_valid !== m_valid || out_data !== m_data
                || out_src !== 2'(m_src)) begin
                errors++;
                $display("FAIL random[%0d] ready=%b valid=%b data=%h src=%0d required %b/%b/%h/%0d",
                         i, got_ready, out_valid, out_data, out_src, exp_ready, m_valid, m_data, m_src);
            end
        end
    endtask

    task automatic test_async_reset();
        mode = 2'b01; in_valid = 4'b1111; in_data = 32'h0F0E0D0C; out_ready = 1'b1;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset valid=%b ready=%b data=%h required 0/0000/00",
                     out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (int'(out_src) != i || out_valid !== 1'b1 || out_data !== in_data[i*8 +: 8]) begin
                errors++;
                $display("FAIL rr_restart[%0d] src=%0d valid=%b data=%h required %0d/1/%h",
                         i, out_src, out_valid, out_data, i, in_data[i*8 +: 8]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_forced_select();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
